pixel_write_arbiter: RTL and testbench

//   Shares the single pixel write port of the 160x120 VGA adapter between NUM_REQ pixel sources
//   (screen clear engine, Bresenham line drawers, coordinate scanner).

---
 rtl/vga_pkg.sv | 16 +
 rtl/rr_pick.sv | 35 +++
 rtl/pixel_write_arbiter.sv | 124 ++++++++++++
 tb/tb_pixel_write_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared constants and state encoding for the VGA pixel path (160x120 adapter).
package vga_pkg;

    localparam int X_MAX   = 159;
    localparam int Y_MAX   = 119;
    localparam int XW      = 8;
    localparam int YW      = 7;
    localparam int CW      = 3;
    localparam int OWNER_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit at or after start, wrapping.
module rr_pick
    import vga_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]       req,
    input  logic [OWNER_W-1:0] start,
    output logic [N-1:0]       gnt,
    output logic [OWNER_W-1:0] idx,
    output logic               any
);

    // Two passes with constant indices: first [start..N-1], then wrap to [0..start-1].
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int unsigned j = 0; j < N; j++) begin
            if (!any && req[j] && (j >= 32'(start))) begin
                gnt[j] = 1'b1;
                idx    = OWNER_W'(j);
                any    = 1'b1;
            end
        end
        for (int unsigned j = 0; j < N; j++) begin
            if (!any && req[j]) begin
                gnt[j] = 1'b1;
                idx    = OWNER_W'(j);
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pixel_write_arbiter.sv
// Round-robin arbiter with burst lock for the VGA adapter pixel write port.
// Optional CLIP_EN: off-screen pixels are acknowledged but not plotted, setting sticky clipped.
module pixel_write_arbiter
    import vga_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int XW      = vga_pkg::XW,
    parameter int YW      = vga_pkg::YW,
    parameter int CW      = vga_pkg::CW
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    lock,
    input  logic [NUM_REQ*XW-1:0] x_in,
    input  logic [NUM_REQ*YW-1:0] y_in,
    input  logic [NUM_REQ*CW-1:0] colour_in,
    input  logic                  ready,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [XW-1:0]         x,
    output logic [YW-1:0]         y,
    output logic [CW-1:0]         colour,
    output logic                  plot,
    output logic [2:0]            owner
`ifdef CLIP_EN
    ,
    output logic                  clipped
`endif
);

    state_t               state, state_nxt;
    logic [OWNER_W-1:0]   pick_start;
    logic [NUM_REQ-1:0]   pick_gnt;
    logic [OWNER_W-1:0]   pick_idx;
    logic                 pick_any;
    logic [OWNER_W-1:0]   gidx;
    logic                 xfer;
    logic [XW-1:0]        sel_x;
    logic [YW-1:0]        sel_y;
    logic [CW-1:0]        sel_c;
    logic                 oob;

    assign pick_start = (owner >= OWNER_W'(NUM_REQ - 1)) ? '0 : owner + 3'd1;

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req   (req),
        .start (pick_start),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_comb begin
        gnt       = '0;
        gidx      = owner;
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (ready && pick_any) begin
                    gnt  = pick_gnt;
                    gidx = pick_idx;
                    if (lock[pick_idx]) state_nxt = BURST;
                end
            end
            BURST: begin
                // Only the owner is considered; lock dropping still grants this last pixel.
                if (ready) begin
                    if (req[owner]) gnt[owner] = 1'b1;
                    if (!(req[owner] && lock[owner])) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign xfer = |gnt;

    always_comb begin
        sel_x = '0;
        sel_y = '0;
        sel_c = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_x = x_in[i*XW +: XW];
                sel_y = y_in[i*YW +: YW];
                sel_c = colour_in[i*CW +: CW];
            end
        end
    end

`ifdef CLIP_EN
    assign oob = (int'(sel_x) > X_MAX) || (int'(sel_y) > Y_MAX);
`else
    assign oob = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            owner  <= OWNER_W'(NUM_REQ - 1);
            x      <= '0;
            y      <= '0;
            colour <= '0;
            plot   <= 1'b0;
        end else begin
            state <= state_nxt;
            plot  <= xfer && !oob;
            if (xfer) begin
                owner  <= gidx;
                x      <= sel_x;
                y      <= sel_y;
                colour <= sel_c;
            end
        end
    end

`ifdef CLIP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) clipped <= 1'b0;
        else if (xfer && oob) clipped <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Self-checking bench for pixel_write_arbiter: directed scenarios plus randomized traffic vs. a model.
module tb_pixel_write_arbiter;

    localparam int N  = 2;
    localparam int XW = 8;
    localparam int YW = 7;
    localparam int CW = 3;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [N-1:0]         req;
    logic [N-1:0]         lock;
    logic [N*XW-1:0]      x_in;
    logic [N*YW-1:0]      y_in;
    logic [N*CW-1:0]      colour_in;
    logic                 ready;
    logic [N-1:0]         gnt;
    logic [XW-1:0]        x;
    logic [YW-1:0]        y;
    logic [CW-1:0]        colour;
    logic                 plot;
    logic [2:0]           owner;
`ifdef CLIP_EN
    logic                 clipped;
`endif

    int checks   = 0;
    int failures = 0;

    int px[N];
    int py[N];
    int pc[N];

    // Reference model state
    int m_owner;
    bit m_burst;
    bit m_plot;
    int m_x, m_y, m_c;
    bit m_clip;

    pixel_write_arbiter #(.NUM_REQ(N), .XW(XW), .YW(YW), .CW(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .lock      (lock),
        .x_in      (x_in),
        .y_in      (y_in),
        .colour_in (colour_in),
        .ready     (ready),
        .gnt       (gnt),
        .x         (x),
        .y         (y),
        .colour    (colour),
        .plot      (plot),
        .owner     (owner)
`ifdef CLIP_EN
        ,
        .clipped   (clipped)
`endif
    );

    always #5 clk = ~clk;

    task automatic pack_inputs();
        for (int i = 0; i < N; i++) begin
            x_in[i*XW +: XW]      = XW'(px[i]);
            y_in[i*YW +: YW]      = YW'(py[i]);
            colour_in[i*CW +: CW] = CW'(pc[i]);
        end
    endtask

    task automatic model_reset();
        m_owner = N - 1;
        m_burst = 1'b0;
        m_plot  = 1'b0;
        m_x = 0; m_y = 0; m_c = 0;
        m_clip  = 1'b0;
    endtask

    function automatic int model_pick();
        if (!ready) return -1;
        if (m_burst) return req[m_owner] ? m_owner : -1;
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_owner + k) % N;
            if (req[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] model_gnt();
        int g;
        g = model_pick();
        if (g < 0) return '0;
        return N'(1) << g;
    endfunction

    task automatic model_step();
        int g;
        bit inr;
        g = model_pick();
        m_plot = 1'b0;
        if (g >= 0) begin
            m_owner = g;
            m_burst = lock[g];
            m_x = px[g]; m_y = py[g]; m_c = pc[g];
            inr = (m_x <= 159) && (m_y <= 119);
`ifdef CLIP_EN
            m_plot = inr;
            if (!inr) m_clip = 1'b1;
`else
            m_plot = 1'b1;
`endif
        end else if (ready) begin
            m_burst = 1'b0;
        end
    endtask

    task automatic tick();
        if (reset) model_reset();
        else model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req = 2'b11; lock = '0; ready = 1'b1;
        for (int i = 0; i < N; i++) begin px[i] = 3 + i; py[i] = 4 + i; pc[i] = i + 1; end
        pack_inputs();
        tick();
        checks++; if (plot !== 1'b0) begin failures++; $display("FAIL reset_plot got=%0b exp=0", plot); end
        checks++; if (owner !== 3'(N-1)) begin failures++; $display("FAIL reset_owner got=%0d exp=%0d", owner, N-1); end
        checks++; if (x !== '0 || y !== '0 || colour !== '0) begin
            failures++; $display("FAIL reset_xyc got=%0d,%0d,%0d exp=0,0,0", x, y, colour); end
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            logic [N-1:0] e;
            e = (c % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            checks++; if (gnt !== e) begin failures++; $display("FAIL rr_gnt cyc=%0d got=%b exp=%b", c, gnt, e); end
            tick();
            checks++; if (plot !== 1'b1) begin failures++; $display("FAIL rr_plot cyc=%0d got=%0b exp=1", c, plot); end
        end
        req = '0;
        tick();
    endtask

    task automatic test_single();
        req = 2'b10; lock = '0; ready = 1'b1;
        px[1] = 10; py[1] = 20; pc[1] = 5;
        pack_inputs();
        #1;
        checks++; if (gnt !== 2'b10) begin failures++; $display("FAIL single_gnt got=%b exp=10", gnt); end
        tick();
        checks++; if (x !== 8'd10 || y !== 7'd20 || colour !== 3'd5 || plot !== 1'b1) begin
            failures++; $display("FAIL single_pixel got=%0d,%0d,%0d,%0b exp=10,20,5,1", x, y, colour, plot); end
        req = '0;
        #1;
        checks++; if (gnt !== 2'b00) begin failures++; $display("FAIL noreq_gnt got=%b exp=00", gnt); end
        tick();
        checks++; if (plot !== 1'b0) begin failures++; $display("FAIL noreq_plot got=%0b exp=0", plot); end
    endtask

    task automatic test_burst();
        req = 2'b11; ready = 1'b1;
        for (int p = 0; p < 4; p++) begin
            lock = (p < 3) ? 2'b01 : 2'b00;
            px[0] = 50 + p; pack_inputs();
            #1;
            checks++; if (gnt !== 2'b01) begin failures++; $display("FAIL burst_gnt p=%0d got=%b exp=01", p, gnt); end
            tick();
            checks++; if (x !== 8'(50 + p) || plot !== 1'b1) begin
                failures++; $display("FAIL burst_pixel p=%0d got=%0d,%0b exp=%0d,1", p, x, plot, 50 + p); end
        end
        #1;
        checks++; if (gnt !== 2'b10) begin failures++; $display("FAIL burst_end_gnt got=%b exp=10", gnt); end
        tick();
        req = '0; lock = '0;
        tick();
    endtask

    task automatic test_stall();
        req = 2'b11; lock = 2'b01; ready = 1'b1;
        for (int p = 0; p < 2; p++) begin
            #1;
            checks++; if (gnt !== 2'b01) begin failures++; $display("FAIL stall_pre_gnt got=%b exp=01", gnt); end
            tick();
        end
        ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            #1;
            checks++; if (gnt !== 2'b00) begin failures++; $display("FAIL stall_gnt s=%0d got=%b exp=00", s, gnt); end
            tick();
            checks++; if (plot !== 1'b0) begin failures++; $display("FAIL stall_plot s=%0d got=%0b exp=0", s, plot); end
        end
        ready = 1'b1;
        #1;
        checks++; if (gnt !== 2'b01) begin failures++; $display("FAIL stall_resume_gnt got=%b exp=01", gnt); end
        tick();
        checks++; if (owner !== 3'd0 || plot !== 1'b1) begin
            failures++; $display("FAIL stall_resume got=%0d,%0b exp=0,1", owner, plot); end
        lock = '0;
        #1;
        checks++; if (gnt !== 2'b01) begin failures++; $display("FAIL stall_last_gnt got=%b exp=01", gnt); end
        tick();
        #1;
        checks++; if (gnt !== 2'b10) begin failures++; $display("FAIL stall_after_gnt got=%b exp=10", gnt); end
        tick();
        req = '0;
        tick();
    endtask

    task automatic test_reset_burst();
        req = 2'b11; lock = 2'b01; ready = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        #1;
        checks++; if (plot !== 1'b0 || owner !== 3'(N-1)) begin
            failures++; $display("FAIL midreset got=%0b,%0d exp=0,%0d", plot, owner, N-1); end
        tick();
        reset = 1'b0; lock = '0;
        #1;
        checks++; if (gnt !== 2'b01) begin failures++; $display("FAIL postreset_gnt got=%b exp=01", gnt); end
        tick();
        req = '0;
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            logic [N-1:0] e;
            for (int i = 0; i < N; i++) begin
                if (!req[i] && $urandom_range(0, 2) != 0) begin
                    req[i] = 1'b1;
                    px[i] = $urandom_range(0, 159); py[i] = $urandom_range(0, 119); pc[i] = $urandom_range(0, 7);
                end
                lock[i] = 1'($urandom_range(0, 1));
            end
            ready = ($urandom_range(0, 4) != 0);
            pack_inputs();
            #1;
            e = model_gnt();
            checks++; if (gnt !== e) begin failures++; $display("FAIL rand_gnt cyc=%0d got=%b exp=%b", c, gnt, e); end
            tick();
            checks++; if (plot !== m_plot || owner !== 3'(m_owner)) begin
                failures++; $display("FAIL rand_plot_owner cyc=%0d got=%0b,%0d exp=%0b,%0d", c, plot, owner, m_plot, m_owner); end
            if (m_plot) begin
                checks++; if (x !== XW'(m_x) || y !== YW'(m_y) || colour !== CW'(m_c)) begin
                    failures++; $display("FAIL rand_pixel cyc=%0d got=%0d,%0d,%0d exp=%0d,%0d,%0d", c, x, y, colour, m_x, m_y, m_c); end
            end
            for (int i = 0; i < N; i++) begin
                if (e[i]) begin
                    req[i] = 1'($urandom_range(0, 1));
                    px[i] = $urandom_range(0, 159); py[i] = $urandom_range(0, 119); pc[i] = $urandom_range(0, 7);
                end
            end
        end
        req = '0; lock = '0; ready = 1'b1;
        tick();
        tick();
    endtask

`ifdef CLIP_EN
    task automatic test_clip();
        reset = 1'b1; req = '0; lock = '0; ready = 1'b1;
        tick();
        reset = 1'b0;
        req = 2'b01; px[0] = 160; py[0] = 5; pc[0] = 2; pack_inputs();
        #1;
        checks++; if (gnt !== 2'b01) begin failures++; $display("FAIL clip_gnt got=%b exp=01", gnt); end
        tick();
        checks++; if (plot !== 1'b0 || clipped !== 1'b1) begin
            failures++; $display("FAIL clip_first got=%0b,%0b exp=0,1", plot, clipped); end
        req = 2'b01; px[0] = 159; py[0] = 119; pack_inputs();
        #1;
        checks++; if (gnt !== 2'b01) begin failures++; $display("FAIL clip_gnt2 got=%b exp=01", gnt); end
        tick();
        checks++; if (plot !== 1'b1 || clipped !== 1'b1 || x !== 8'd159 || y !== 7'd119) begin
            failures++; $display("FAIL clip_second got=%0b,%0b,%0d,%0d exp=1,1,159,119", plot, clipped, x, y); end
        req = '0;
        tick();
    endtask
`endif

    initial begin
        reset = 1'b1; req = '0; lock = '0; ready = 1'b1;
        x_in = '0; y_in = '0; colour_in = '0;
        model_reset();
        test_reset();
        test_single();
        test_burst();
        test_stall();
        test_reset_burst();
        test_random();
`ifdef CLIP_EN
        test_clip();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
